// File: rtl/rsa_xcel_naive_mod_exp_ctrl_if.sv
// Stream bundle around the modular-exponentiation sequencer.
// master = sequencer side. slave = the environment side: front end, sink and mul-rem unit.
interface rsa_xcel_naive_mod_exp_ctrl_if #(
  parameter int p_nbits = 32
);
  logic [3*p_nbits-1:0] istream_msg;
  logic                 istream_val;
  logic                 istream_rdy;
  logic [p_nbits-1:0]   ostream_msg;
  logic                 ostream_val;
  logic                 ostream_rdy;
  logic [3*p_nbits-1:0] mr_req_msg;
  logic                 mr_req_val;
  logic                 mr_req_rdy;
  logic [p_nbits-1:0]   mr_resp_msg;
  logic                 mr_resp_val;
  logic                 mr_resp_rdy;

  modport master (
    input  istream_msg, istream_val,
    output istream_rdy,
    output ostream_msg, ostream_val,
    input  ostream_rdy,
    output mr_req_msg, mr_req_val,
    input  mr_req_rdy,
    input  mr_resp_msg, mr_resp_val,
    output mr_resp_rdy
  );

  modport slave (
    output istream_msg, istream_val,
    input  istream_rdy,
    input  ostream_msg, ostream_val,
    output ostream_rdy,
    input  mr_req_msg, mr_req_val,
    output mr_req_rdy,
    output mr_resp_msg, mr_resp_val,
    input  mr_resp_rdy
  );
endinterface

// File: rtl/rsa_xcel_naive_mod_exp_ctrl.sv
// Right-to-left square-and-multiply sequencer computing base^exp mod n.
// It keeps at most one request outstanding to an external mul-rem unit.
//
// state      | meaning
// S_IDLE     | ready for a job; latches {n, base, exp} on accept
// S_MUL_REQ  | issue acc*base mod n
// S_MUL_WAIT | wait for the multiply result into acc
// S_SQ_REQ   | issue base*base mod n
// S_SQ_WAIT  | wait for the square result into base; shift exp
// S_DONE     | present acc on ostream until consumed
//
// The last squaring is skipped. DONE is reached from MUL_WAIT only when
// exp has shrunk to 1, or directly from IDLE for trivial jobs.
module rsa_xcel_naive_mod_exp_ctrl #(
  parameter int p_nbits = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  rsa_xcel_naive_mod_exp_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_MUL_REQ, S_MUL_WAIT, S_SQ_REQ, S_SQ_WAIT, S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [p_nbits-1:0]   r_n;
  logic [p_nbits-1:0]   r_base;
  logic [p_nbits-1:0]   r_exp;
  logic [p_nbits-1:0]   r_acc;

  logic [p_nbits-1:0]   w_in_n;
  logic [p_nbits-1:0]   w_in_base;
  logic [p_nbits-1:0]   w_in_exp;
  logic                 w_n_trivial;
  logic                 w_exp_is_one;
  logic                 w_istream_rdy;
  logic                 w_ostream_val;
  logic                 w_req_val;
  logic                 w_req_is_mul;
  logic                 w_resp_rdy;

  assign w_in_n       = bus.istream_msg[3*p_nbits-1:2*p_nbits];
  assign w_in_base    = bus.istream_msg[2*p_nbits-1:p_nbits];
  assign w_in_exp     = bus.istream_msg[p_nbits-1:0];
  // n of 0 or 1 makes every residue 0.
  assign w_n_trivial  = (w_in_n[p_nbits-1:1] == '0);
  assign w_exp_is_one = (r_exp == {{(p_nbits-1){1'b0}}, 1'b1});

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_istream_rdy = 1'b0;
    w_ostream_val = 1'b0;
    w_req_val     = 1'b0;
    w_req_is_mul  = 1'b0;
    w_resp_rdy    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_istream_rdy = 1'b1;
        if (bus.istream_val) begin
          if (w_n_trivial || (w_in_exp == '0)) w_state_nxt = S_DONE;
          else if (w_in_exp[0])                w_state_nxt = S_MUL_REQ;
          else                                 w_state_nxt = S_SQ_REQ;
        end
      end
      S_MUL_REQ: begin
        w_req_val    = 1'b1;
        w_req_is_mul = 1'b1;
        if (bus.mr_req_rdy) w_state_nxt = S_MUL_WAIT;
      end
      S_MUL_WAIT: begin
        w_resp_rdy = 1'b1;
        if (bus.mr_resp_val) w_state_nxt = w_exp_is_one ? S_DONE : S_SQ_REQ;
      end
      S_SQ_REQ: begin
        w_req_val = 1'b1;
        if (bus.mr_req_rdy) w_state_nxt = S_SQ_WAIT;
      end
      S_SQ_WAIT: begin
        w_resp_rdy = 1'b1;
        // r_exp[1] is the low bit of exp after this step's shift.
        if (bus.mr_resp_val) w_state_nxt = r_exp[1] ? S_MUL_REQ : S_SQ_REQ;
      end
      S_DONE: begin
        w_ostream_val = 1'b1;
        if (bus.ostream_rdy) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand, exponent and accumulator registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_n    <= '0;
      r_base <= '0;
      r_exp  <= '0;
      r_acc  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.istream_val) begin
            r_n    <= w_in_n;
            r_base <= w_in_base;
            r_exp  <= w_in_exp;
            r_acc  <= w_n_trivial ? '0 : {{(p_nbits-1){1'b0}}, 1'b1};
          end
        end
        S_MUL_WAIT: begin
          if (bus.mr_resp_val) r_acc <= bus.mr_resp_msg;
        end
        S_SQ_WAIT: begin
          if (bus.mr_resp_val) begin
            r_base <= bus.mr_resp_msg;
            r_exp  <= r_exp >> 1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.istream_rdy = w_istream_rdy;
  assign bus.ostream_val = w_ostream_val;
  assign bus.ostream_msg = r_acc;
  assign bus.mr_req_val  = w_req_val;
  assign bus.mr_req_msg  = {r_n, (w_req_is_mul ? r_acc : r_base), r_base};
  assign bus.mr_resp_rdy = w_resp_rdy;

endmodule

// File: tb/tb_rsa_xcel_naive_mod_exp_ctrl.sv
// Bench for the mod-exp sequencer. A behavioural model derives the expected request
// list from the bits of exp. It plays the mul-rem unit and the sink. Each negedge it
// checks the DUT against the model, and final results against an independent
// left-to-right modexp.
`timescale 1ns/1ps
module tb_rsa_xcel_naive_mod_exp_ctrl;
  localparam int NB = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  rsa_xcel_naive_mod_exp_ctrl_if #(.p_nbits(NB)) bus();
  rsa_xcel_naive_mod_exp_ctrl #(.p_nbits(NB)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk_b(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0b required %0b (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_w(input string name, input logic [95:0] act, input logic [95:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Independent reference: left-to-right binary exponentiation.
  function automatic logic [31:0] golden(input logic [31:0] n, input logic [31:0] b,
                                         input logic [31:0] e);
    logic [63:0] r;
    if (n < 32'd2) return 32'd0;
    r = 64'd1;
    for (int i = 31; i >= 0; i--) begin
      r = (r * r) % {32'd0, n};
      if (e[i]) r = (r * {32'd0, b}) % {32'd0, n};
    end
    return r[31:0];
  endfunction

  // Model state
  logic [95:0] jq[$];
  bit          reqq[$];          // 1 = multiply, 0 = square
  bit          busy = 0, outstanding = 0, pend_is_mul = 0, in_sq_wait = 0;
  bit          stall = 0, first_seen = 0, first_is_sq = 0;
  logic [31:0] m_n = '0, m_acc = '0, m_base = '0, m_result = '0;
  logic [31:0] pend_resp = '0, last_out = '0;
  int          ohold = 0, done_cnt = 0, mul_cnt = 0, sq_cnt = 0;

  task automatic accept(input logic [95:0] j);
    logic [31:0] n, b, e;
    int msb;
    n = j[95:64]; b = j[63:32]; e = j[31:0];
    busy = 1; m_n = n; m_base = b; m_result = golden(n, b, e);
    mul_cnt = 0; sq_cnt = 0; first_seen = 0; first_is_sq = 0;
    m_acc = (n < 32'd2) ? 32'd0 : 32'd1;
    reqq.delete();
    if (n >= 32'd2 && e != 32'd0) begin
      msb = 0;
      for (int i = 0; i < 32; i++) if (e[i]) msb = i;
      for (int i = 0; i <= msb; i++) begin
        if (e[i]) reqq.push_back(1'b1);
        if (i < msb) reqq.push_back(1'b0);
      end
    end
  endtask

  // Per-cycle model, environment driver and compare process.
  initial begin
    bit          exp_req_val, exp_oval, kind, ordy;
    logic [31:0] opa;
    bus.istream_val = 0; bus.istream_msg = '0;
    bus.ostream_rdy = 0; bus.mr_req_rdy = 0;
    bus.mr_resp_val = 0; bus.mr_resp_msg = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk_b("rst_istream_rdy", bus.istream_rdy, 1'b1);
        chk_b("rst_ostream_val", bus.ostream_val, 1'b0);
        chk_b("rst_mr_req_val", bus.mr_req_val, 1'b0);
        chk_b("rst_mr_resp_rdy", bus.mr_resp_rdy, 1'b0);
        chk_w("rst_ostream_msg", 96'(bus.ostream_msg), 96'd0);
        busy = 0; outstanding = 0; in_sq_wait = 0; reqq.delete();
        bus.istream_val = 0; bus.ostream_rdy = 0;
        bus.mr_req_rdy = 0; bus.mr_resp_val = 0;
        continue;
      end
      in_sq_wait  = outstanding && !pend_is_mul;
      exp_req_val = busy && (reqq.size() > 0) && !outstanding;
      exp_oval    = busy && (reqq.size() == 0) && !outstanding;
      chk_b("istream_rdy", bus.istream_rdy, !busy);
      chk_b("ostream_val", bus.ostream_val, exp_oval);
      chk_b("mr_req_val", bus.mr_req_val, exp_req_val);
      chk_b("mr_resp_rdy", bus.mr_resp_rdy, outstanding);
      if (exp_req_val)
        chk_w("mr_req_msg", bus.mr_req_msg,
              {m_n, (reqq[0] ? m_acc : m_base), m_base});
      if (exp_oval)
        chk_w("ostream_msg", 96'(bus.ostream_msg), 96'(m_result));

      // Drive the environment for the coming edge.
      if (jq.size() > 0) begin
        bus.istream_val = 1; bus.istream_msg = jq[0];
      end else begin
        bus.istream_val = 0; bus.istream_msg = {$urandom, $urandom, $urandom};
      end
      bus.mr_req_rdy  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.mr_resp_val = outstanding && (stall ? ($urandom_range(0, 2) == 0) : 1'b1);
      bus.mr_resp_msg = outstanding ? pend_resp : $urandom;
      if (exp_oval && ohold > 0) begin
        ordy = 0; ohold--;
      end else begin
        ordy = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
      bus.ostream_rdy = ordy;

      // Handshakes that fire on the coming edge.
      if (jq.size() > 0 && !busy) begin
        accept(jq.pop_front());
      end else if (exp_req_val && bus.mr_req_rdy) begin
        kind = reqq.pop_front();
        if (!first_seen) begin first_seen = 1; first_is_sq = !kind; end
        if (kind) mul_cnt++; else sq_cnt++;
        opa = kind ? m_acc : m_base;
        pend_resp   = 32'(({32'd0, opa} * {32'd0, m_base}) % {32'd0, m_n});
        pend_is_mul = kind;
        outstanding = 1;
      end else if (outstanding && bus.mr_resp_val) begin
        if (pend_is_mul) m_acc = pend_resp; else m_base = pend_resp;
        outstanding = 0;
      end else if (exp_oval && ordy) begin
        busy = 0; last_out = bus.ostream_msg; done_cnt++;
      end
    end
  end

  task automatic wait_done(input int target, input string name);
    int cyc;
    cyc = 0;
    while (done_cnt < target && cyc < 20000) begin
      @(negedge clk); cyc++;
    end
    total++;
    if (done_cnt < target) begin
      bad++;
      $display("FAIL %s_timeout: done=%0d required=%0d", name, done_cnt, target);
    end
  endtask

  task automatic run_job(input logic [31:0] n, input logic [31:0] b, input logic [31:0] e,
                         input string name);
    int target;
    @(negedge clk); #1;
    target = done_cnt + 1;
    jq.push_back({n, b, e});
    wait_done(target, name);
    @(negedge clk); #1;
  endtask

  initial begin
    int  cyc, target;
    bit  found;
    logic [31:0] rn, rb, re;

    chk_w("golden_pin_4_13", 96'(golden(32'd497, 32'd4, 32'd13)), 96'd445);
    chk_w("golden_pin_2_10", 96'(golden(32'd1000, 32'd2, 32'd10)), 96'd24);
    repeat (3) @(negedge clk);
    #1 reset = 1;

    run_job(32'd497, 32'd4, 32'd13, "job_4_13");
    chk_w("res_4_13", 96'(last_out), 96'd445);
    chk_w("mul_4_13", 96'(mul_cnt), 96'd3);
    chk_w("sq_4_13", 96'(sq_cnt), 96'd3);

    run_job(32'd1000, 32'd2, 32'd10, "job_2_10");
    chk_w("res_2_10", 96'(last_out), 96'd24);
    chk_w("mul_2_10", 96'(mul_cnt), 96'd2);
    chk_w("sq_2_10", 96'(sq_cnt), 96'd3);
    chk_b("first_sq_2_10", first_is_sq, 1'b1);

    run_job(32'd13, 32'd7, 32'd0, "triv_exp0");
    chk_w("res_triv_exp0", 96'(last_out), 96'd1);
    chk_w("reqs_triv_exp0", 96'(mul_cnt + sq_cnt), 96'd0);
    run_job(32'd1, 32'd5, 32'd3, "triv_n1");
    chk_w("res_triv_n1", 96'(last_out), 96'd0);
    chk_w("reqs_triv_n1", 96'(mul_cnt + sq_cnt), 96'd0);
    run_job(32'd0, 32'd9, 32'd4, "triv_n0");
    chk_w("res_triv_n0", 96'(last_out), 96'd0);
    chk_w("reqs_triv_n0", 96'(mul_cnt + sq_cnt), 96'd0);

    // Backpressure on every interface plus a 5-cycle held sink.
    stall = 1; ohold = 5;
    run_job(32'd497, 32'd4, 32'd13, "bp_4_13");
    chk_w("res_bp_4_13", 96'(last_out), 96'd445);
    chk_w("ohold_used", 96'(ohold), 96'd0);
    stall = 0;

    // Reset while waiting on a square response.
    jq.push_back({32'd497, 32'd4, 32'd13});
    cyc = 0; found = 0;
    while (!found && cyc < 200) begin
      @(negedge clk); #1; cyc++;
      if (in_sq_wait) found = 1;
    end
    chk_b("reached_sq_wait", found, 1'b1);
    target = done_cnt;
    reset = 0;
    #1;
    chk_b("rst_now_istream_rdy", bus.istream_rdy, 1'b1);
    chk_b("rst_now_ostream_val", bus.ostream_val, 1'b0);
    chk_b("rst_now_mr_req_val", bus.mr_req_val, 1'b0);
    chk_b("rst_now_mr_resp_rdy", bus.mr_resp_rdy, 1'b0);
    repeat (3) @(negedge clk);
    #1 reset = 1;
    repeat (2) @(negedge clk);
    chk_w("no_output_after_abort", 96'(done_cnt), 96'(target));
    run_job(32'd1000, 32'd2, 32'd10, "post_rst_2_10");
    chk_w("res_post_rst", 96'(last_out), 96'd24);

    // Back-to-back random jobs with random stalls.
    stall = 1;
    @(negedge clk); #1;
    target = done_cnt + 10;
    for (int k = 0; k < 10; k++) begin
      rn = $urandom; if (rn < 32'd2) rn = 32'd2;
      rb = $urandom; re = $urandom;
      jq.push_back({rn, rb, re});
    end
    wait_done(target, "random_jobs");
    stall = 0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
